reg_write_arbiter: RTL and testbench

//  Shares the single write path of a bank of reg32 registers among NUM_REQ requesters.

---
 rtl/reg_write_arbiter_pkg.sv | 19 +
 rtl/reg_write_arbiter_rr_pick.sv | 31 +++
 rtl/reg_write_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared parameters, types and helpers for the register write arbiter.
package reg_write_arbiter_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int NUM_REGS_DEF  = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int BURST_W       = 4;

  typedef enum logic {
    ST_FREE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or above i_ptr, wrapping to 0.
module reg_write_arbiter_rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int N     = NUM_REQ_DEF,
  parameter int PTR_W = addr_w(NUM_REQ_DEF)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic             o_any
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter with locked bursts sharing one registered write port into a reg32 bank.
//
// state    | meaning
// ST_FREE  | round-robin from r_ptr among all requesters
// ST_OWNED | only r_owner may transfer; others wait until released or burst limit hit
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int ADDR_W    = addr_w(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rstbar,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REGS-1:0]       reg_we,
  output logic [31:0]               reg_wdata,
  output logic                      owner_vld
);

  localparam int PTR_W = addr_w(NUM_REQ);

  arb_state_t          r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [BURST_W-1:0]  r_burst_cnt;
  logic [NUM_REGS-1:0] r_reg_we;
  logic [31:0]         r_reg_wdata;

  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic                w_pick_any;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic                w_xfer;
  logic [PTR_W-1:0]    w_win_idx;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [31:0]         w_win_data;
  logic [NUM_REGS-1:0] w_we_next;
  logic                w_keep;
  logic                w_idle_release;
  logic [PTR_W-1:0]    w_win_next;
  logic [PTR_W-1:0]    w_owner_next;

  reg_write_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_any (w_pick_any)
  );

  // Grant is forced low during reset so nothing looks accepted while the bank is cleared.
  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
    if (!rstbar) begin
      gnt    = '0;
      w_xfer = 1'b0;
    end else if (r_state == ST_OWNED) begin
      gnt    = req & w_owner_oh;
      w_xfer = req[r_owner];
    end else begin
      gnt    = w_pick_gnt;
      w_xfer = w_pick_any;
    end
  end

  always_comb begin
    w_win_idx  = '0;
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        w_win_idx  = PTR_W'(i);
        w_win_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_win_data = req_wdata[i*32 +: 32];
      end
    end
    w_we_next = '0;
    if (w_xfer && (int'(w_win_addr) < NUM_REGS))
      w_we_next[w_win_addr] = 1'b1;
  end

  assign w_keep         = lock[w_win_idx] && (int'(r_burst_cnt) < MAX_BURST - 1);
  assign w_idle_release = (r_state == ST_OWNED) && !req[r_owner] && !lock[r_owner];
  assign w_win_next     = (int'(w_win_idx) == NUM_REQ - 1) ? '0 : w_win_idx + 1'b1;
  assign w_owner_next   = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge rstbar) begin
    if (!rstbar) begin
      r_state     <= ST_FREE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_reg_we    <= '0;
      r_reg_wdata <= '0;
    end else if (w_xfer) begin
      r_reg_we    <= w_we_next;
      r_reg_wdata <= w_win_data;
      if (w_keep) begin
        r_state     <= ST_OWNED;
        r_owner     <= w_win_idx;
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end else begin
        r_state     <= ST_FREE;
        r_burst_cnt <= '0;
        r_ptr       <= w_win_next;
      end
    end else begin
      r_reg_we <= '0;
      if (w_idle_release) begin
        r_state     <= ST_FREE;
        r_burst_cnt <= '0;
        r_ptr       <= w_owner_next;
      end
    end
  end

  assign reg_we    = r_reg_we;
  assign reg_wdata = r_reg_wdata;
  assign owner_vld = (r_state == ST_OWNED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed scenarios plus constrained-random traffic against a behavioural arbiter model.
module tb_reg_write_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 6;
  localparam int MAXB  = 4;
  localparam int AW    = 3;

  logic           clk = 1'b0;
  logic           rstbar = 1'b0;
  logic [3:0]     req = '0;
  logic [3:0]     lock = '0;
  logic [11:0]    req_addr = '0;
  logic [127:0]   req_wdata = '0;
  logic [3:0]     gnt;
  logic [5:0]     reg_we;
  logic [31:0]    reg_wdata;
  logic           owner_vld;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_ptr, m_owner, m_cnt;
  bit          m_owned;
  logic [5:0]  exp_we;
  logic [31:0] exp_wd;
  logic [3:0]  m_gnt;

  logic [3:0]  obs_gnt;
  logic [5:0]  obs_we;
  logic [31:0] obs_wd;

  reg_write_arbiter #(
    .NUM_REQ   (NREQ),
    .NUM_REGS  (NREGS),
    .MAX_BURST (MAXB)
  ) dut (
    .clk       (clk),
    .rstbar    (rstbar),
    .req       (req),
    .lock      (lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .owner_vld (owner_vld)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_gnt(input logic [3:0] r);
    logic [3:0] g;
    g = '0;
    if (m_owned) begin
      if (r[m_owner]) g[m_owner] = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (r[j]) begin
          g[j] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_owned = 1'b0;
    exp_we = '0; exp_wd = '0;
  endtask

  task automatic model_edge();
    int w;
    int a;
    w = -1;
    for (int i = 0; i < NREQ; i++) if (m_gnt[i]) w = i;
    if (w >= 0) begin
      a = int'(req_addr[w*AW +: AW]);
      exp_we = (a < NREGS) ? 6'(1 << a) : 6'd0;
      exp_wd = req_wdata[w*32 +: 32];
      if (lock[w] && m_cnt < MAXB - 1) begin
        m_owned = 1'b1; m_owner = w; m_cnt++;
      end else begin
        m_owned = 1'b0; m_cnt = 0; m_ptr = (w + 1) % NREQ;
      end
    end else begin
      exp_we = '0;
      if (m_owned && !req[m_owner] && !lock[m_owner]) begin
        m_owned = 1'b0; m_cnt = 0; m_ptr = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic step(input logic [3:0] rq, input logic [3:0] lk,
                      input logic [11:0] ad, input logic [127:0] wd);
    @(negedge clk);
    obs_we = reg_we;
    obs_wd = reg_wdata;
    check_val("reg_we", 32'(reg_we), 32'(exp_we));
    check_val("reg_wdata", reg_wdata, exp_wd);
    check_val("owner_vld", 32'(owner_vld), 32'(m_owned));
    req = rq; lock = lk; req_addr = ad; req_wdata = wd;
    #1;
    m_gnt   = model_gnt(req);
    obs_gnt = gnt;
    check_val("gnt", 32'(gnt), 32'(m_gnt));
    @(posedge clk);
    model_edge();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstbar = 1'b1; req = '0; lock = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstbar = 1'b0; req = 4'hF; lock = '0;
    #1;
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_we", 32'(reg_we), 32'd0);
    check_val("rst_wdata", reg_wdata, 32'd0);
    check_val("rst_owner", 32'(owner_vld), 32'd0);
    model_reset();
    release_reset();
  endtask

  initial begin
    logic [3:0]   rq, lk;
    logic [11:0]  ad;
    logic [127:0] wd;

    model_reset();
    #12;
    do_reset();
    step(4'hF, 4'h0, 12'h000, 128'h0);
    check_val("first_gnt", 32'(obs_gnt), 32'd1);

    do_reset();
    ad = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 4'h0, ad, {32'hA3, 32'hA2, 32'hA1, 32'(k)});
      check_val("rr_gnt", 32'(obs_gnt), 32'(1 << (k % 4)));
      if (k > 0) check_val("rr_we", 32'(obs_we), 32'(1 << (((k - 1) % 4) + 1)));
    end

    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(4'b0011, 4'b0001, {3'd0, 3'd0, 3'd1, 3'd2}, {64'h0, 32'hB1, 32'(k)});
      if (k < 4) check_val("burst_gnt0", 32'(obs_gnt), 32'd1);
      if (k == 4) check_val("burst_gnt1", 32'(obs_gnt), 32'd2);
      #2;
      if (k < 4) check_val("burst_own", 32'(owner_vld), 32'(k < 3));
    end

    do_reset();
    step(4'b0001, 4'b0001, 12'h000, 128'h11);
    check_val("idle_first", 32'(obs_gnt), 32'd1);
    step(4'b0100, 4'b0001, 12'h000, 128'h0);
    check_val("idle_wait", 32'(obs_gnt), 32'd0);
    #2 check_val("idle_held", 32'(owner_vld), 32'd1);
    step(4'b0100, 4'b0000, 12'h000, 128'h0);
    check_val("idle_rel_gnt", 32'(obs_gnt), 32'd0);
    #2 check_val("idle_rel", 32'(owner_vld), 32'd0);
    step(4'b0100, 4'b0000, 12'h000, 128'h0);
    check_val("idle_gnt2", 32'(obs_gnt), 32'd4);

    do_reset();
    step(4'b1000, 4'h0, {3'd5, 9'd0}, {32'hDEADBEEF, 96'd0});
    check_val("dp_gnt", 32'(obs_gnt), 32'd8);
    step(4'b0000, 4'h0, {3'd5, 9'd0}, {32'hDEADBEEF, 96'd0});
    check_val("dp_we", 32'(obs_we), 32'h20);
    check_val("dp_wdata", obs_wd, 32'hDEADBEEF);
    step(4'b1000, 4'h0, {3'd7, 9'd0}, {32'h12345678, 96'd0});
    step(4'b0000, 4'h0, 12'h000, 128'h0);
    check_val("oor_we", 32'(obs_we), 32'd0);

    step(4'b0010, 4'b0000, 12'h000, 128'h0);
    step(4'b0100, 4'b0100, {3'd0, 3'd2, 3'd1, 3'd0}, {32'h0, 32'hC0FFEE, 64'h0});
    #2;
    check_val("mid_pre_own", 32'(owner_vld), 32'd1);
    check_val("mid_pre_we", 32'(reg_we), 32'h04);
    rstbar = 1'b0;
    #1;
    check_val("mid_rst_own", 32'(owner_vld), 32'd0);
    check_val("mid_rst_we", 32'(reg_we), 32'd0);
    check_val("mid_rst_wdata", reg_wdata, 32'd0);
    check_val("mid_rst_gnt", 32'(gnt), 32'd0);
    model_reset();
    release_reset();
    step(4'hF, 4'h0, 12'h000, 128'h0);
    check_val("post_rst_gnt", 32'(obs_gnt), 32'd1);

    for (int c = 0; c < 600; c++) begin
      rq = req; ad = req_addr; wd = req_wdata;
      for (int i = 0; i < NREQ; i++) begin
        if (!(req[i] && !obs_gnt[i])) begin
          rq[i]          = 1'($urandom_range(0, 1));
          ad[i*AW +: AW] = 3'($urandom_range(0, 7));
          wd[i*32 +: 32] = $urandom;
        end
      end
      lk = (c % 100 < 50) ? 4'($urandom) : 4'($urandom) | 4'($urandom);
      step(rq, lk, ad, wd);
    end
    step(4'h0, 4'h0, 12'h000, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
